// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase sequencer: state codes,
// one-hot lamp patterns and the last-served requester flag.
package traffic_pkg;

    typedef enum logic [2:0] {
        StMainG   = 3'd0,
        StMainY   = 3'd1,
        StClrA    = 3'd2,
        StSideG   = 3'd3,
        StSideY   = 3'd4,
        StClrB    = 3'd5,
        StPedWalk = 3'd6
    } state_e;

    // {R,Y,G} one-hot lamp patterns
    localparam logic [2:0] Red = 3'b100;
    localparam logic [2:0] Yel = 3'b010;
    localparam logic [2:0] Grn = 3'b001;

    typedef enum logic {
        SrvSide = 1'b0,
        SrvPed  = 1'b1
    } srv_e;

endpackage

// File: rtl/tick_gen.sv
// Divides inClk down to a one-cycle tick every TICK_DIV cycles; the first
// tick arrives TICK_DIV cycles after reset is released.
module tick_gen #(
    parameter int unsigned TICK_DIV = 5
) (
    input  logic inClk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CntW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge inClk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Main-road-priority light sequencer: rests on main green, then serves the
// side road or the pedestrian crossing, alternating when both are waiting.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 5,
    parameter int unsigned MIN_GREEN    = 20,
    parameter int unsigned YELLOW_T     = 4,
    parameter int unsigned CLEAR_T      = 2,
    parameter int unsigned SIDE_GREEN_T = 10,
    parameter int unsigned WALK_T       = 8
) (
    input  logic       inClk,
    input  logic       reset,
    input  logic       sideReq,
    input  logic       pedReq,
    output logic [2:0] mainLight,
    output logic [2:0] sideLight,
    output logic       walk,
    output logic       pedAck,
    output logic [2:0] phase
);

    logic tick;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .inClk(inClk),
        .reset(reset),
        .tick (tick)
    );

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       side_pend_q, side_pend_d;
    logic       ped_pend_q, ped_pend_d;
    srv_e       last_srv_q, last_srv_d;
    logic [2:0] main_light_q, main_light_d;
    logic [2:0] side_light_q, side_light_d;
    logic       walk_q, walk_d;
    logic       ped_ack_q, ped_ack_d;
    logic       expired;
    logic       entering;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        side_pend_d  = side_pend_q;
        ped_pend_d   = ped_pend_q;
        last_srv_d   = last_srv_q;
        main_light_d = Red;
        side_light_d = Red;
        expired      = tick && (timer_q == 8'd0);

        unique case (state_q)
            StMainG:   if (expired && (side_pend_q || ped_pend_q)) state_d = StMainY;
            StMainY:   if (expired) state_d = StClrA;
            StClrA: begin
                if (expired) begin
                    // On a tie, the requester not served last goes next
                    if (side_pend_q && ped_pend_q) begin
                        state_d = (last_srv_q == SrvPed) ? StSideG : StPedWalk;
                    end else if (side_pend_q) begin
                        state_d = StSideG;
                    end else if (ped_pend_q) begin
                        state_d = StPedWalk;
                    end else begin
                        state_d = StClrB;
                    end
                end
            end
            StSideG:   if (expired) state_d = StSideY;
            StSideY:   if (expired) state_d = StClrB;
            StPedWalk: if (expired) state_d = StClrB;
            StClrB:    if (expired) state_d = StMainG;
            default:   state_d = StMainG;
        endcase

        entering = (state_d != state_q);

        if (entering) begin
            unique case (state_d)
                StMainG:          timer_d = 8'(MIN_GREEN - 1);
                StMainY, StSideY: timer_d = 8'(YELLOW_T - 1);
                StClrA, StClrB:   timer_d = 8'(CLEAR_T - 1);
                StSideG:          timer_d = 8'(SIDE_GREEN_T - 1);
                StPedWalk:        timer_d = 8'(WALK_T - 1);
                default:          timer_d = 8'(MIN_GREEN - 1);
            endcase
        end else if (tick && (timer_q != 8'd0)) begin
            timer_d = timer_q - 8'd1;
        end

        if (sideReq && (state_q != StSideG) && (state_q != StSideY)) side_pend_d = 1'b1;
        if (pedReq && (state_q != StPedWalk)) ped_pend_d = 1'b1;
        // Entry into a service state clears its request even if re-asserted now
        if (entering && (state_d == StSideG)) begin
            side_pend_d = 1'b0;
            last_srv_d  = SrvSide;
        end
        if (entering && (state_d == StPedWalk)) begin
            ped_pend_d = 1'b0;
            last_srv_d = SrvPed;
        end

        if (state_d == StMainG) main_light_d = Grn;
        if (state_d == StMainY) main_light_d = Yel;
        if (state_d == StSideG) side_light_d = Grn;
        if (state_d == StSideY) side_light_d = Yel;
        walk_d    = (state_d == StPedWalk);
        ped_ack_d = entering && (state_d == StPedWalk);
    end

    always_ff @(posedge inClk) begin
        if (reset) begin
            state_q      <= StMainG;
            timer_q      <= 8'(MIN_GREEN - 1);
            side_pend_q  <= 1'b0;
            ped_pend_q   <= 1'b0;
            last_srv_q   <= SrvPed;
            main_light_q <= Grn;
            side_light_q <= Red;
            walk_q       <= 1'b0;
            ped_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            side_pend_q  <= side_pend_d;
            ped_pend_q   <= ped_pend_d;
            last_srv_q   <= last_srv_d;
            main_light_q <= main_light_d;
            side_light_q <= side_light_d;
            walk_q       <= walk_d;
            ped_ack_q    <= ped_ack_d;
        end
    end

    assign mainLight = main_light_q;
    assign sideLight = side_light_q;
    assign walk      = walk_q;
    assign pedAck    = ped_ack_q;
    assign phase     = state_q;

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Sequences the intersection's light phases from a divided time base and arbitrates between two requesters, the side-road sensor and the pedestrian button. Main road rests on green; a pending request, once minimum green has elapsed, triggers yellow, all-red clearance, and service of the winning requester. An internal tick generator derives the phase time base from `inClk`. All durations are counted in ticks.

## Interface
- `TICK_DIV`, 5: `inClk` cycles per tick (≥2).
- `MIN_GREEN`, 20: minimum main-green ticks (≥1).
- `YELLOW_T`, 4: yellow ticks, both roads (≥1).
- `CLEAR_T`, 2: all-red clearance ticks (≥1).
- `SIDE_GREEN_T`, 10: side-green ticks (≥1).
- `WALK_T`, 8: pedestrian walk ticks (≥1).
- `inClk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `sideReq`  in  1  side-road vehicle present (level).
- `pedReq`  in  1  pedestrian button (level).
- `mainLight`  out  3  {R,Y,G} one-hot, main road.
- `sideLight`  out  3  {R,Y,G} one-hot, side road.
- `walk`  out  1  pedestrian walk lamp.
- `pedAck`  out  1  one-cycle pulse when walk begins.
- `phase`  out  3  current state encoding (debug).

## Operation
- States: MAIN_G(0), MAIN_Y(1), CLR_A(2), SIDE_G(3), SIDE_Y(4), CLR_B(5), PED_WALK(6).
- Lights: MAIN_G main G, side R. MAIN_Y main Y, side R. SIDE_G main R, side G. SIDE_Y main R, side Y. CLR_A, CLR_B and PED_WALK are all red. `walk`=1 only in PED_WALK.
- Pending latches: `sidePend` sets on any cycle with `sideReq`=1 except in SIDE_G/SIDE_Y. `pedPend` sets on `pedReq`=1 except in PED_WALK. Each clears on entry to its service state. Set and clear in the same cycle: clear wins.
- Timer (8-bit): loaded with duration−1 on state entry. Decrements on tick and holds at 0. A state expires on a tick with timer==0.
- MAIN_G: leave to MAIN_Y on a tick with timer==0 and (`sidePend`|`pedPend`). Otherwise hold indefinitely.
- MAIN_Y→CLR_A on expiry.
- CLR_A on expiry:
  - Only side pending: go to SIDE_G.
  - Only ped pending: go to PED_WALK.
  - Both pending: the one not served last wins (`lastSrv` bit, reset = PED, so side wins the first tie). `lastSrv` updates on entry.
- SIDE_G→SIDE_Y→CLR_B on expiry. PED_WALK→CLR_B on expiry. CLR_B→MAIN_G on expiry. Main green is always revisited between services.

## Timing
- Tick generator: counter 0..TICK_DIV−1, wraps. `tick`=1 for one cycle when counter==TICK_DIV−1. Reset clears the counter to 0, so the first tick comes TICK_DIV cycles after reset deasserts.
- State, lights, `walk` and `phase` are registered. They change on the `inClk` edge that consumes the expiring tick.
- `pedAck` is registered high in the same cycle `walk` first becomes 1.
- Reset values: state MAIN_G, mainLight=001, sideLight=100, walk=0, pedAck=0, phase=0, timer=MIN_GREEN−1, pending latches=0, tick counter=0.
- Reset mid-phase (e.g. in SIDE_G) returns to MAIN_G on the next edge. The full minimum green applies again.
- A request arriving after MIN_GREEN has elapsed is acted on at the next tick boundary.

## Structure
- Shared package `traffic_pkg` holds:
  - the state encoding constants;
  - light encodings RED=3'b100, YEL=3'b010, GRN=3'b001;
  - the `lastSrv` encodings SIDE/PED.
- Sub-module `tick_gen`, parameter `TICK_DIV`, ports `inClk`, `reset`, `tick`. The FSM and arbitration live in the top module.

## Test plan
- Use TICK_DIV=2, MIN_GREEN=3, YELLOW_T=2, CLEAR_T=1, SIDE_GREEN_T=2, WALK_T=2.
- Reset with no requests for 100 cycles → stays MAIN_G, mainLight=001, sideLight=100, no `pedAck`.
- `sideReq` pulse at cycle 1 → MAIN_Y at the 3rd tick (cycle 6 after reset), CLR_A 2 ticks later, SIDE_G 1 tick later, then SIDE_Y, CLR_B, MAIN_G.
- `pedReq` pulse after 10 ticks of idle → MAIN_Y at the next tick. `pedAck` is a single cycle coincident with `walk` rising. `walk` lasts exactly 2 ticks.
- `sideReq` and `pedReq` asserted together and held → serves SIDE_G, MAIN_G ≥3 ticks, PED_WALK, MAIN_G, SIDE_G (alternation).
- `pedReq` held high throughout PED_WALK → not re-latched; returns to MAIN_G and stays there once `pedReq` drops.
- `reset` asserted in SIDE_G → next cycle MAIN_G with reset output values. Requests issued before reset are lost.
